idli_utx_m: RTL and testbench
=============================

Name: idli_utx_m

Overview:
UART transmitter downstream of the execution stage, driving the top-level o_top_uart_tx pin.
- Accepts 16-bit words from the core as four 4-bit slices, one per GCK, over a sync-counter period.
- Buffers them as bytes in a small FIFO.
- Serialises the bytes as 8N1 frames, LSB first, at a fixed GCK divider.
- Applies backpressure to the core through a ready flag.

Parameters:
BAUD_DIV, 4, GCK cycles per UART bit; at least 2.
FIFO_DEPTH, 8, byte entries; power of 2, at least 2.

Ports:
i_utx_gck  in  1  global clock
i_utx_rst  in  1  reset, synchronous, active-high
i_utx_ctr  in  2  core sync counter (ctr_t); 0..3 per word
i_utx_valid  in  1  word to send; held for all 4 cycles of the period
i_utx_data  in  4  data slice (slice_t); least significant slice at ctr==0
o_utx_ready  out  1  at least 2 free FIFO bytes; constant across a period
o_utx_tx  out  1  serial line; idle high
o_utx_busy  out  1  FIFO not empty or frame in progress

Behaviour:
Reset (i_utx_rst high at a posedge):
- Next cycle: o_utx_tx=1, o_utx_ready=1, o_utx_busy=0.
- FIFO pointers and count cleared; FSM to IDLE; bit and baud counters zero.
- A frame in flight is abandoned: line returns high immediately.

Acceptance:
- A word is accepted iff i_utx_valid && o_utx_ready while i_utx_ctr==0.
- An accept flag holds for cycles 0..3 of that period.
- Slices shift into a 16-bit assembly register at ctr 0,1,2,3.
- i_utx_valid changes at ctr!=0 are ignored.

Push:
- On ctr==3 with accept set, the FIFO is written with 2 bytes in one cycle: bits[7:0] at wptr, bits[15:8] at wptr+1.
- wptr += 2; count += 2.
- Pointers wrap modulo FIFO_DEPTH.

Ready:
- o_utx_ready is a flop loaded at ctr==3 with (FIFO_DEPTH - count_next >= 2), where count_next includes this cycle's push and pop.
- Held constant for cycles 0..3 of the following period.
- Overflow is therefore impossible; the bench asserts it.

Pop:
- FSM in IDLE with count != 0 pops one byte: rptr += 1, count -= 1.
- Push and pop in the same cycle gives net count += 1.

Serialiser FSM (each non-IDLE state lasts exactly BAUD_DIV cycles, timed by the baud counter):
- IDLE: tx=1. Count != 0: load shifter, go START.
- START: tx=0, then DATA with bit index 0.
- DATA: tx=shift[0]. At end of bit: shift right. Bit index 7 goes to PARITY if enabled, else STOP.
- STOP: tx=1. At end: go IDLE.
- Back-to-back frames: IDLE lasts one cycle between frames, so the stop bit is effectively BAUD_DIV+1 cycles.

o_utx_busy = (count != 0) || (state != IDLE), registered.

Optional Feature:
IDLI_UTX_PARITY_EN:
- Defined: PARITY state inserted after DATA. tx = XOR of the 8 data bits (even parity) for BAUD_DIV cycles.
- Undefined: no PARITY state; frame is 10 bit-times.

Decomposition:
- idli_pkg: utx_state_t enum (IDLE, START, DATA, PARITY, STOP) and UTX_FRAME_BITS.
- Existing slice_t, ctr_t and data_t are reused.
- Sub-module idli_utx_fifo_m: dual-byte-write / single-byte-read FIFO with count.
- idli_utx_m keeps assembly, ready logic and FSM.

Test Plan:
- Reset: drive rst for 2 cycles mid-frame -> next cycle tx=1, busy=0, ready=1; no further edges on tx.
- Single word: BAUD_DIV=4, send 0x1234 -> line frame 0x34 then 0x12; start bit low for 4 cycles; 40 cycles per frame with parity off, 44 with IDLI_UTX_PARITY_EN; parity bit = 1 for 0x34, 0 for 0x12.
- Valid at ctr!=0 only: valid high at ctr 1..3, low at ctr 0 -> nothing accepted; tx stays high; busy=0.
- Backpressure: FIFO_DEPTH=8, send 5 consecutive words (0x0001..0x0005) -> ready drops after the 4th word is pushed; 5th held until a pop frees 2 entries; bytes emerge in order 01 00 02 00 .. 05 00; no loss.
- Simultaneous push/pop: push on the ctr==3 cycle where IDLE pops -> count correct (+1 net); ready value matches count_next.
- Wrap-around: stream 20 words with BAUD_DIV=2 -> pointers wrap repeatedly; serialised byte sequence equals input bytes low-then-high.

Source files
------------

// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared core types plus UART transmitter state and frame length (IDLI_UTX_PARITY_EN)
package idli_pkg;

    typedef logic [3:0]  slice_t;
    typedef logic [1:0]  ctr_t;
    typedef logic [15:0] data_t;
    typedef logic [7:0]  byte_t;

    typedef enum logic [2:0] {
        UTX_IDLE,
        UTX_START,
        UTX_DATA,
        UTX_PARITY,
        UTX_STOP
    } utx_state_t;

`ifdef IDLI_UTX_PARITY_EN
    localparam int UTX_FRAME_BITS = 11;
`else
    localparam int UTX_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/idli_utx_fifo_m.sv
// rtl/idli_utx_fifo_m.sv - byte FIFO taking two bytes per write and giving one byte per read
module idli_utx_fifo_m
    import idli_pkg::*;
#(
    parameter int   FIFO_DEPTH = 8,
    localparam int  PTR_W      = $clog2(FIFO_DEPTH),
    localparam int  CNT_W      = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  data_t            i_wdata,
    input  logic             i_pop,
    output byte_t            o_rdata,
    output logic [CNT_W-1:0] o_count,
    output logic [CNT_W-1:0] o_count_next
);

    byte_t            mem_q [FIFO_DEPTH];
    byte_t            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] wptr_inc;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wptr_inc = wptr_q + PTR_W'(1);
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        // Low byte first so the serialiser emits it first; pointers wrap by width.
        if (i_push) begin
            mem_d[wptr_q]   = i_wdata[7:0];
            mem_d[wptr_inc] = i_wdata[15:8];
            wptr_d          = wptr_q + PTR_W'(2);
            count_d         = count_d + CNT_W'(2);
        end
        if (i_pop) begin
            rptr_d  = rptr_q + PTR_W'(1);
            count_d = count_d - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign o_rdata      = mem_q[rptr_q];
    assign o_count      = count_q;
    assign o_count_next = count_d;

endmodule

// File: rtl/idli_utx_m.sv
// rtl/idli_utx_m.sv - UART 8N1 transmitter fed 4-bit slices by the core; IDLI_UTX_PARITY_EN adds even parity
module idli_utx_m
    import idli_pkg::*;
#(
    parameter int BAUD_DIV   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic   i_utx_gck,
    input  logic   i_utx_rst,
    input  ctr_t   i_utx_ctr,
    input  logic   i_utx_valid,
    input  slice_t i_utx_data,
    output logic   o_utx_ready,
    output logic   o_utx_tx,
    output logic   o_utx_busy
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int               BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

    logic              accept_q, accept_d;
    logic [11:0]       asm_q, asm_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    utx_state_t        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    byte_t             shift_q, shift_d;
`ifdef IDLI_UTX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              push;
    logic              pop;
    logic              bit_end;
    logic              tx;
    data_t             word;
    byte_t             rdata;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    idli_utx_fifo_m #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk        (i_utx_gck),
        .i_rst        (i_utx_rst),
        .i_push       (push),
        .i_wdata      (word),
        .i_pop        (pop),
        .o_rdata      (rdata),
        .o_count      (count),
        .o_count_next (count_next)
    );

    // The accept decision is taken once at ctr==0 and held for the period.
    always_comb begin
        accept_d = accept_q;
        if (i_utx_ctr == 2'd0) begin
            accept_d = i_utx_valid && ready_q;
        end
        asm_d = {i_utx_data, asm_q[11:4]};
        word  = {i_utx_data, asm_q};
        push  = accept_d && (i_utx_ctr == 2'd3);
    end

    always_comb begin
        ready_d = ready_q;
        if (i_utx_ctr == 2'd3) begin
            ready_d = (count_next <= READY_MAX);
        end
        busy_d = (count_next != '0) || (state_d != UTX_IDLE);
    end

    always_ff @(posedge i_utx_gck) begin
        if (i_utx_rst) begin
            state_q  <= UTX_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            accept_q <= 1'b0;
            asm_q    <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
`ifdef IDLI_UTX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            accept_q <= accept_d;
            asm_q    <= asm_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
`ifdef IDLI_UTX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        bit_end = (baud_q == BAUD_LAST);
`ifdef IDLI_UTX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != UTX_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end
        case (state_q)
            UTX_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = rdata;
                    baud_d  = '0;
                    state_d = UTX_START;
`ifdef IDLI_UTX_PARITY_EN
                    parity_d = ^rdata;
`endif
                end
            end
            UTX_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = UTX_DATA;
                end
            end
            UTX_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef IDLI_UTX_PARITY_EN
                        state_d = UTX_PARITY;
`else
                        state_d = UTX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            UTX_PARITY: begin
                if (bit_end) begin
                    state_d = UTX_STOP;
                end
            end
            UTX_STOP: begin
                if (bit_end) begin
                    state_d = UTX_IDLE;
                end
            end
            default: begin
                state_d = UTX_IDLE;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            UTX_START:  tx = 1'b0;
            UTX_DATA:   tx = shift_q[0];
`ifdef IDLI_UTX_PARITY_EN
            UTX_PARITY: tx = parity_q;
`endif
            default:    tx = 1'b1;
        endcase
    end

    assign o_utx_tx    = tx;
    assign o_utx_ready = ready_q;
    assign o_utx_busy  = busy_q;

endmodule

// File: tb/tb_idli_utx_m.sv
// tb/tb_idli_utx_m.sv - randomized self-checking bench for idli_utx_m with a frame-level line model
module tb_idli_utx_m;
    import idli_pkg::*;

    localparam int BD    = 4;
    localparam int DEPTH = 8;
    localparam int FB    = UTX_FRAME_BITS;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [1:0] ctr   = 2'd0;
    logic       valid = 1'b0;
    logic [3:0] data  = 4'h0;
    logic       ready, tx, busy;

    idli_utx_m #(
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_utx_gck   (clk),
        .i_utx_rst   (rst),
        .i_utx_ctr   (ctr),
        .i_utx_valid (valid),
        .i_utx_data  (data),
        .o_utx_ready (ready),
        .o_utx_tx    (tx),
        .o_utx_busy  (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    bit          started  = 0;
    logic [1:0]  g_ctr    = 2'd0;

    logic [7:0]  m_q[$];
    bit          m_line[$];
    bit          m_ready = 1;
    bit          m_acc   = 0;
    logic [15:0] m_word  = '0;
    logic [7:0]  exp_q[$];

    bit          rx_active = 0;
    int          rx_cyc    = 0;
    int          rx_t0     = 0;
    logic [7:0]  rx_byte   = '0;
    bit          rx_par    = 0;
    logic [7:0]  rx_q[$];
    int          rx_t[$];
    bit          rx_p[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_busy();
        return (m_q.size() != 0) || (m_line.size() != 0);
    endfunction

    function automatic logic [7:0] rxb(input int i);
        return (rx_q.size() > i) ? rx_q[i] : 8'hxx;
    endfunction

    function automatic int rxt(input int i);
        return (rx_t.size() > i) ? rx_t[i] : -1000;
    endfunction

    function automatic bit rxp(input int i);
        return (rx_p.size() > i) ? rx_p[i] : 1'bx;
    endfunction

    // Line monitor, UART receiver and reference model; the model advance at
    // each negedge stands for the posedge that follows it.
    initial forever begin : mon
        int         k;
        logic [7:0] b;
        bit         v;
        @(negedge clk);
        cyc++;
        if (started) begin
            check("tx", tx, (m_line.size() != 0) ? m_line[0] : 1'b1);
            check("ready", ready, m_ready);
            check("busy", busy, m_busy());
            check("no_overflow", dut.u_fifo.count_q > DEPTH, 0);

            if (!rx_active) begin
                if (tx === 1'b0) begin
                    rx_active = 1;
                    rx_cyc    = 0;
                    rx_t0     = cyc;
                    rx_byte   = '0;
                    rx_par    = 0;
                end
            end else begin
                rx_cyc++;
            end
            if (rx_active && (rx_cyc % BD) == BD / 2) begin
                k = rx_cyc / BD;
                if (k == 0) begin
                    check("rx_start", tx, 0);
                end else if (k <= 8) begin
                    rx_byte[k-1] = tx;
                end else if (k < FB - 1) begin
                    rx_par = tx;
                end else begin
                    check("rx_stop", tx, 1);
                    rx_q.push_back(rx_byte);
                    rx_t.push_back(rx_t0);
                    rx_p.push_back(rx_par);
                    rx_active = 0;
                end
            end
        end

        if (rst) begin
            m_q.delete();
            m_line.delete();
            exp_q.delete();
            rx_q.delete();
            rx_t.delete();
            rx_p.delete();
            rx_active = 0;
            m_ready   = 1;
            m_acc     = 0;
            started   = 1;
        end else begin
            if (m_line.size() != 0) begin
                void'(m_line.pop_front());
            end else if (m_q.size() != 0) begin
                b = m_q.pop_front();
                for (int i = 0; i < FB; i++) begin
                    if (i == 0)           v = 0;
                    else if (i <= 8)      v = b[i-1];
                    else if (i < FB - 1)  v = ^b;
                    else                  v = 1;
                    repeat (BD) m_line.push_back(v);
                end
            end
            if (ctr == 2'd0) m_acc = valid && m_ready;
            if (m_acc) m_word[int'(ctr)*4 +: 4] = data;
            if (ctr == 2'd3) begin
                if (m_acc) begin
                    m_q.push_back(m_word[7:0]);
                    m_q.push_back(m_word[15:8]);
                    exp_q.push_back(m_word[7:0]);
                    exp_q.push_back(m_word[15:8]);
                end
                m_ready = (DEPTH - m_q.size()) >= 2;
            end
        end
    end

    task automatic step(input bit v, input logic [3:0] d, input bit r);
        @(posedge clk);
        #1;
        ctr   = g_ctr;
        valid = v;
        data  = d;
        rst   = r;
        g_ctr = g_ctr + 2'd1;
    endtask

    task automatic send_period(input logic [3:0] vmask, input logic [15:0] w);
        while (g_ctr != 2'd0) step(0, 4'h0, 0);
        for (int c = 0; c < 4; c++) step(vmask[c], w[4*c +: 4], 0);
    endtask

    task automatic send_word_hold(input logic [15:0] w);
        int tries;
        tries = 0;
        do begin
            tries++;
            send_period(4'hF, w);
        end while (!m_acc && tries < 60);
        check("hold_accept", m_acc, 1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            if (i >= 4 && !m_busy() && !rx_active) break;
            step(0, 4'h0, 0);
        end
        check("drain_done", i < 3000, 1);
    endtask

    task automatic scoreboard(input string name);
        check({name, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) check({name, "_byte"}, rxb(i), exp_q[i]);
        rx_q.delete();
        rx_t.delete();
        rx_p.delete();
        exp_q.delete();
    endtask

    initial begin
        int          tries;
        logic [15:0] w;
        bit          lowseen;

        repeat (3) step(0, 4'h0, 1);
        step(0, 4'h0, 0);
        check("rst_tx", tx, 1);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);

        send_period(4'hF, 16'h1234);
        drain();
        check("w1234_nbytes", rx_q.size(), 2);
        check("w1234_b0", rxb(0), 8'h34);
        check("w1234_b1", rxb(1), 8'h12);
`ifdef IDLI_UTX_PARITY_EN
        check("w1234_gap", rxt(1) - rxt(0), 45);
        check("w1234_par0", rxp(0), 1);
        check("w1234_par1", rxp(1), 0);
`else
        check("w1234_gap", rxt(1) - rxt(0), 41);
`endif
        scoreboard("w1234");

        repeat (4) send_period(4'b1110, 16'hFFFF);
        repeat (8) step(0, 4'h0, 0);
        check("nz_busy", busy, 0);
        check("nz_tx", tx, 1);
        check("nz_rx", rx_q.size(), 0);

        for (int n = 1; n <= 4; n++) send_period(4'hF, 16'(n));
        w     = 16'h0005;
        tries = 0;
        do begin
            tries++;
            for (int c = 0; c < 4; c++) begin
                step(1, w[4*c +: 4], 0);
                if (tries == 1 && c == 0) check("bp_ready_low", ready, 0);
            end
        end while (!m_acc && tries < 40);
`ifdef IDLI_UTX_PARITY_EN
        check("bp_tries", tries, 10);
`else
        check("bp_tries", tries, 9);
`endif
        drain();
        check("bp_nbytes", rx_q.size(), 10);
        for (int i = 0; i < 10; i++) check("bp_lit", rxb(i), (i % 2 == 0) ? (i / 2 + 1) : 0);
        scoreboard("bp");

        for (int n = 0; n < 20; n++) send_word_hold(16'($urandom));
        drain();
        scoreboard("stream");

        repeat (40) send_period(($urandom_range(0, 3) != 0) ? 4'hF : 4'h0, 16'($urandom));
        drain();
        scoreboard("rand");

        send_period(4'hF, 16'hABCD);
        repeat (20) step(0, 4'h0, 0);
        step(0, 4'h0, 1);
        step(0, 4'h0, 1);
        step(0, 4'h0, 0);
        check("rst2_tx", tx, 1);
        check("rst2_ready", ready, 1);
        check("rst2_busy", busy, 0);
        lowseen = 0;
        repeat (50) begin
            step(0, 4'h0, 0);
            if (tx !== 1'b1) lowseen = 1;
        end
        check("rst2_quiet", lowseen, 0);
        check("rst2_no_rx", rx_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule
